// File: rtl/npc_gen.sv
// Next-PC generator: fetch PC register with prioritised redirect selection.
// Optional return-address stack is compiled in when NPC_RAS_EN is defined.
module npc_gen #(
    parameter int          IDX_W      = 26,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter int          RAS_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [31:0]      base_pc,
    input  logic             br_taken,
    input  logic [15:0]      br_offset,
    input  logic             j_valid,
    input  logic [IDX_W-1:0] j_index,
    input  logic             j_link,
    input  logic             jr_valid,
    input  logic [31:0]      jr_target,
    input  logic             ras_pop,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [31:0]      epc,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             pc_misalign,
    output logic [31:0]      ras_top,
    output logic             ras_valid
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] base_plus4;
    logic [31:0] j_target;
    logic [31:0] br_target;
    logic        upd_ok;
    logic        jal_sel;

    assign base_plus4 = base_pc + 32'd4;
    // J-type keeps the region bits of the delay-slot PC above the index field
    assign j_target   = {base_plus4[31:IDX_W+2], j_index, 2'b00};
    assign br_target  = base_plus4 + {{14{br_offset[15]}}, br_offset, 2'b00};

    assign upd_ok  = ~stall & ~exc_req & ~eret_req;
    assign jal_sel = upd_ok & ~jr_valid & j_valid;

    always_comb begin
        pc_d = pc_q + 32'd4;
        if (exc_req)       pc_d = HANDLER_PC;
        else if (eret_req) pc_d = epc;
        else if (stall)    pc_d = pc_q;
        else if (jr_valid) pc_d = jr_target;
        else if (j_valid)  pc_d = j_target;
        else if (br_taken) pc_d = br_target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign pc_misalign = |pc_q[1:0];

`ifdef NPC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [31:0]      ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, wr_ptr;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             push, pop, wr_en;

    assign push = jal_sel & j_link;
    assign pop  = upd_ok & ras_pop & (cnt_q != '0);

    // Push with pop replaces the top; a full push wraps onto the oldest slot.
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_ptr = ptr_q;
        if (push && pop) begin
            wr_en = 1'b1;
        end else if (push) begin
            wr_en  = 1'b1;
            wr_ptr = ptr_q + PTR_W'(1);
            ptr_d  = ptr_q + PTR_W'(1);
            if (cnt_q != (PTR_W+1)'(RAS_DEPTH)) cnt_d = cnt_q + (PTR_W+1)'(1);
        end else if (pop) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) ras_mem[wr_ptr] <= base_pc + 32'd8;
    end

    assign ras_valid = (cnt_q != '0);
    assign ras_top   = ras_valid ? ras_mem[ptr_q] : 32'd0;
`else
    logic unused_ras;
    assign unused_ras = j_link ^ ras_pop ^ jal_sel;
    assign ras_top    = 32'd0;
    assign ras_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_npc_gen.sv
// Scoreboard bench for npc_gen: stimulus pushes expected PC/RAS state,
// a monitor pops and compares after every rising edge.
module tb_npc_gen;
    localparam int IDX_W = 26;
`ifdef NPC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic             clk, rst_n, stall, br_taken, j_valid, j_link;
    logic             jr_valid, ras_pop, exc_req, eret_req;
    logic [31:0]      base_pc, jr_target, epc;
    logic [15:0]      br_offset;
    logic [IDX_W-1:0] j_index;
    logic [31:0]      pc, pc_plus4, ras_top;
    logic             pc_misalign, ras_valid;

    npc_gen #(.IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .base_pc(base_pc),
        .br_taken(br_taken), .br_offset(br_offset), .j_valid(j_valid),
        .j_index(j_index), .j_link(j_link), .jr_valid(jr_valid),
        .jr_target(jr_target), .ras_pop(ras_pop), .exc_req(exc_req),
        .eret_req(eret_req), .epc(epc), .pc(pc), .pc_plus4(pc_plus4),
        .pc_misalign(pc_misalign), .ras_top(ras_top), .ras_valid(ras_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] top;
        logic        valid;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic idle();
        stall = 0; br_taken = 0; j_valid = 0; j_link = 0; jr_valid = 0;
        ras_pop = 0; exc_req = 0; eret_req = 0;
        base_pc = 0; jr_target = 0; epc = 0; br_offset = 0; j_index = '0;
    endtask

    task automatic nxt();
        @(negedge clk);
        idle();
    endtask

    task automatic expect_state(input string name, input logic [31:0] exp_pc,
                                input logic [31:0] exp_top, input logic exp_valid);
        exp_t e;
        e.name  = name;
        e.pc    = exp_pc;
        e.top   = RAS_ON ? exp_top : 32'd0;
        e.valid = RAS_ON ? exp_valid : 1'b0;
        sb.push_back(e);
    endtask

    task automatic jal(input logic [31:0] base);
        j_valid = 1; j_link = 1; base_pc = base; j_index = 26'h000_0C00;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if (pc !== e.pc) begin
                    n_miss++;
                    $display("FAIL %s pc: got %h expected %h", e.name, pc, e.pc);
                end
                if (pc_plus4 !== e.pc + 32'd4) begin
                    n_miss++;
                    $display("FAIL %s pc_plus4: got %h expected %h", e.name, pc_plus4, e.pc + 32'd4);
                end
                if (pc_misalign !== (e.pc[1:0] != 2'b00)) begin
                    n_miss++;
                    $display("FAIL %s pc_misalign: got %b expected %b", e.name, pc_misalign, e.pc[1:0] != 2'b00);
                end
                if (ras_valid !== e.valid) begin
                    n_miss++;
                    $display("FAIL %s ras_valid: got %b expected %b", e.name, ras_valid, e.valid);
                end
                if (ras_top !== e.top) begin
                    n_miss++;
                    $display("FAIL %s ras_top: got %h expected %h", e.name, ras_top, e.top);
                end
                $display("vec %0d %s pc=%h ras_top=%h ras_valid=%b", n_vec, e.name, pc, ras_top, ras_valid);
            end
        end
    end

    // Stimulus
    initial begin
        rst_n = 0;
        idle();
        @(negedge clk); expect_state("reset", 32'h0000_3000, 0, 0);
        @(negedge clk); rst_n = 1; expect_state("seq0", 32'h0000_3004, 0, 0);
        nxt(); expect_state("seq1", 32'h0000_3008, 0, 0);
        nxt(); j_valid = 1; base_pc = 32'hA000_3010; j_index = 26'h000_0C40;
               expect_state("jump", 32'hA000_3100, 0, 0);
        nxt(); br_taken = 1; base_pc = 32'h0000_3020; br_offset = 16'hFFFC;
               expect_state("br_neg", 32'h0000_3014, 0, 0);
        nxt(); jr_valid = 1; jr_target = 32'hFFFF_FFFC;
               expect_state("jr_top", 32'hFFFF_FFFC, 0, 0);
        nxt(); expect_state("wrap", 32'h0000_0000, 0, 0);
        nxt(); exc_req = 1; eret_req = 1; jr_valid = 1; jr_target = 32'h5554; stall = 1;
               expect_state("prio_exc", 32'h0000_4180, 0, 0);
        nxt(); eret_req = 1; epc = 32'h0000_3046;
               expect_state("eret_mis", 32'h0000_3046, 0, 0);
        nxt(); stall = 1; expect_state("stall1", 32'h0000_3046, 0, 0);
        nxt(); stall = 1; br_taken = 1; base_pc = 32'h3000; br_offset = 16'h0004;
               expect_state("stall2", 32'h0000_3046, 0, 0);
        nxt(); stall = 1; expect_state("stall3", 32'h0000_3046, 0, 0);
        nxt(); expect_state("br_lost", 32'h0000_304A, 0, 0);
        nxt(); jr_valid = 1; jr_target = 32'h5000; j_valid = 1; j_index = 26'h000_1000;
               base_pc = 32'h3000; br_taken = 1; br_offset = 16'h0010;
               expect_state("jr_wins", 32'h0000_5000, 0, 0);
        nxt(); j_valid = 1; j_index = 26'h000_1000; base_pc = 32'h3000;
               br_taken = 1; br_offset = 16'h0010;
               expect_state("j_wins", 32'h0000_4000, 0, 0);
        nxt(); eret_req = 1; epc = 32'h0000_8000; expect_state("eret", 32'h0000_8000, 0, 0);
        nxt(); exc_req = 1; expect_state("exc", 32'h0000_4180, 0, 0);

        // Asynchronous reset mid-redirect
        nxt(); jr_valid = 1; jr_target = 32'h7000; rst_n = 0;
        #1;
        n_vec++;
        if (pc !== 32'h0000_3000) begin
            n_miss++;
            $display("FAIL rst_async pc: got %h expected %h", pc, 32'h0000_3000);
        end
        $display("vec %0d rst_async pc=%h", n_vec, pc);
        expect_state("rst_hold", 32'h0000_3000, 0, 0);
        nxt(); rst_n = 1; expect_state("rst_rel", 32'h0000_3004, 0, 0);

        // Return-address stack
        for (int k = 0; k < 5; k++) begin
            nxt(); jal(32'h3000 + 32'(4 * k));
            expect_state("ras_push", 32'h0000_3000, 32'h3008 + 32'(4 * k), 1);
        end
        nxt(); ras_pop = 1; expect_state("ras_pop1", 32'h3004, 32'h3014, 1);
        nxt(); ras_pop = 1; expect_state("ras_pop2", 32'h3008, 32'h3010, 1);
        nxt(); ras_pop = 1; expect_state("ras_pop3", 32'h300C, 32'h300C, 1);
        nxt(); ras_pop = 1; expect_state("ras_pop4", 32'h3010, 32'h0, 0);
        nxt(); ras_pop = 1; expect_state("ras_pop_empty", 32'h3014, 32'h0, 0);
        nxt(); jal(32'h3100); expect_state("ras_push_a", 32'h3000, 32'h3108, 1);
        nxt(); jal(32'h3104); expect_state("ras_push_b", 32'h3000, 32'h310C, 1);
        nxt(); jal(32'h3200); ras_pop = 1;
               expect_state("ras_push_pop", 32'h3000, 32'h3208, 1);
        nxt(); ras_pop = 1; expect_state("ras_pop_after", 32'h3004, 32'h3108, 1);
        nxt(); jal(32'h3400); jr_valid = 1; jr_target = 32'h3000;
               expect_state("ras_jr_blocks", 32'h3000, 32'h3108, 1);
        nxt(); stall = 1; jal(32'h3300); ras_pop = 1;
               expect_state("ras_stall", 32'h3000, 32'h3108, 1);
        nxt(); exc_req = 1; ras_pop = 1; expect_state("ras_exc", 32'h4180, 32'h3108, 1);
        nxt(); expect_state("ras_idle", 32'h4184, 32'h3108, 1);

        nxt();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/npc_gen.md
# npc_gen

Parametrised next-PC generator for the pipelined MIPS core. It holds the fetch PC register and selects the next value each cycle from sequential, branch, J-type, register-jump, exception-entry and ERET sources. J-type targets are formed by region concatenation, generalised to any index width. It sits in front of the instruction memory and takes redirect requests from the decode/execute stages and the CP0 block; an optional return-address stack is compiled in for call/return prediction.

## Interface
Parameters:
- IDX_W, 26, J-type index width; region bits retained from PC = 32-IDX_W-2 (IDX_W range 16..29)
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- HANDLER_PC, 32'h0000_4180, exception entry address
- RAS_DEPTH, 4, return-address stack entries (power of two, 2..16; used only with NPC_RAS_EN)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- stall  in  1  hold PC and RAS
- base_pc  in  32  PC of the branch/jump instruction
- br_taken  in  1  conditional branch taken
- br_offset  in  16  branch immediate, signed, in words
- j_valid  in  1  J-type jump
- j_index  in  IDX_W  J-type index field
- j_link  in  1  jump is a call (jal); pushes RAS
- jr_valid  in  1  register jump
- jr_target  in  32  register jump target
- ras_pop  in  1  return consumed; pops RAS
- exc_req  in  1  exception entry
- eret_req  in  1  return from exception
- epc  in  32  CP0 EPC value
- pc  out  32  current fetch PC
- pc_plus4  out  32  pc + 4 (combinational)
- pc_misalign  out  1  pc[1:0] != 0 (combinational from pc)
- ras_top  out  32  predicted return address
- ras_valid  out  1  RAS non-empty

## Operation
- Next-PC priority, highest first: exc_req -> HANDLER_PC; eret_req -> epc; stall -> hold; jr_valid -> jr_target; j_valid -> {base_pc+4 [31:IDX_W+2], j_index, 2'b00}; br_taken -> base_pc + 4 + (sext(br_offset) << 2); else pc + 4.
- exc_req and eret_req override stall; eret_req is ignored when exc_req is also asserted.
- Several of jr/j/br asserted together: resolved by priority, no error.
- All additions are modulo 2^32; wrap from 32'hFFFF_FFFC to 0 without a flag.
- Misaligned jr_target/epc is loaded unchanged; pc_misalign reports it for the exception logic.
- RAS (NPC_RAS_EN): circular stack of RAS_DEPTH entries plus a saturating count.
  - Push value is base_pc + 8.
  - Push occurs when j_valid & j_link is the selected source.
  - Pop occurs on ras_pop when not stalled.
  - Push and pop together: top entry is replaced; count is unchanged.
  - Push when full: oldest entry is overwritten; count stays RAS_DEPTH.
  - Pop when empty: no effect.
  - exc_req, eret_req and stall block all RAS updates.

## Timing
- Reset: pc = RESET_PC; RAS count = 0; ras_valid = 0; ras_top = 0.
- Reset is asynchronous in both directions. Deasserting it mid-redirect discards the request; the first post-reset edge fetches from RESET_PC + 4 unless a redirect is presented.
- Latency is one cycle: a redirect sampled at edge N appears on pc after edge N.
- pc_plus4 and pc_misalign are combinational from pc.
- ras_top and ras_valid are registered and reflect pushes and pops from the previous edge.
- Redirect inputs are level-sampled with no handshake. The requester holds a redirect for exactly the cycle it is valid; a redirect asserted during stall is lost unless re-presented.

## Configuration
- NPC_RAS_EN defined: return-address stack is built as described above.
- NPC_RAS_EN undefined: no RAS storage; ras_top ties to 0 and ras_valid to 0; j_link and ras_pop are ignored. PC behaviour is otherwise identical.

## Test plan
- Reset and sequential fetch: hold rst_n low, release -> pc = 32'h3000, then 32'h3004, 32'h3008 on successive edges.
- J-type jump: base_pc = 32'hA000_3010, j_index = 26'h000_0C40, j_valid -> pc = 32'hA000_3100 next cycle.
- Branch, negative offset and wrap: base_pc = 32'h0000_3020, br_offset = 16'hFFFC, br_taken -> pc = 32'h0000_3014. Separately, pc = 32'hFFFF_FFFC with no redirect -> pc = 0.
- Priority: exc_req, eret_req, jr_valid and stall all asserted -> pc = 32'h4180. Next cycle, eret_req with epc = 32'h3046 -> pc = 32'h3046 and pc_misalign = 1.
- Stall hold: stall = 1 for 3 cycles with br_taken pulsed in cycle 2 -> pc unchanged throughout and the branch is lost.
- RAS (NPC_RAS_EN, RAS_DEPTH = 4):
  - 5 jal pushes from base_pc 32'h3000..32'h3010 -> ras_top = 32'h3018, count = 4.
  - 4 pops -> ras_top = 32'h3014, 32'h3010, 32'h300C in turn, then ras_valid = 0.
  - A further pop -> no change.
